// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: architectural register file with a load scoreboard.
//
// Reads are combinational. Results are written back from two sources:
//   - the ALU, which writes immediately;
//   - loads, which return from memory in issue order.
// Each register has a pending-load counter. An in-order FIFO of load
// destination registers routes each returning response to its register.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   rd_addr / rd_data   NRD packed read ports; port i uses slice [i*W +: W]
//   rd_busy             per read port: the addressed register has a load pending
//   alu_we/waddr/wdata  ALU write-back
//   ld_issue, ld_rd     load issue request and its destination register
//   ld_issue_ready      a load can be accepted this cycle
//   ld_resp_valid/data  load response, returned in issue order
//   ld_outstanding      number of loads in flight
//   resp_err            sticky: a response arrived with nothing outstanding
//
// Build option REGFILE_BYPASS_EN:
//   Defined:   the write landing this cycle is forwarded to rd_data, with
//              a load response taking priority over an ALU write.
//              rd_busy drops in the same cycle as the last response for
//              that register.
//   Undefined: reads show registered state only.

module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int MAX_LD = 4,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(MAX_LD) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                alu_we,
  input  logic [AW-1:0]       alu_waddr,
  input  logic [XLEN-1:0]     alu_wdata,
  input  logic                ld_issue,
  input  logic [AW-1:0]       ld_rd,
  output logic                ld_issue_ready,
  input  logic                ld_resp_valid,
  input  logic [XLEN-1:0]     ld_resp_data,
  output logic [CW-1:0]       ld_outstanding,
  output logic                resp_err
);

  localparam int PW = $clog2(MAX_LD);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LD);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [CW-1:0]   pend_q [NREGS];
  logic [CW-1:0]   pend_d [NREGS];
  logic [AW-1:0]   fifo_q [MAX_LD];
  logic [AW-1:0]   fifo_d [MAX_LD];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            issue_acc;
  logic            resp_acc;
  logic [AW-1:0]   head;

  // Readiness depends only on registered occupancy. A response arriving in
  // the same cycle does not free a slot until the next cycle.
  always_comb begin
    issue_acc = ld_issue && (cnt_q < MAX_CNT);
    resp_acc  = ld_resp_valid && (cnt_q != '0);
    head      = fifo_q[rptr_q];
  end

  // Register write-back: the load response is applied last, so it wins over
  // an ALU write to the same register in the same cycle.
  always_comb begin
    for (int r = 0; r < NREGS; r++) regs_d[r] = regs_q[r];
    if (alu_we) regs_d[alu_waddr] = alu_wdata;
    if (resp_acc) regs_d[head] = ld_resp_data;
    regs_d[0] = '0;
  end

  // Pending counters. An issue and a response to the same register in the
  // same cycle cancel out. Register 0 never counts as pending.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      pend_d[r] = pend_q[r];
      if (r != 0) begin
        if (issue_acc && (ld_rd == AW'(r))) pend_d[r] = pend_d[r] + CW'(1);
        if (resp_acc && (head == AW'(r)))   pend_d[r] = pend_d[r] - CW'(1);
      end
    end
  end

  // Destination FIFO and occupancy.
  always_comb begin
    for (int i = 0; i < MAX_LD; i++) fifo_d[i] = fifo_q[i];
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (issue_acc) begin
      fifo_d[wptr_q] = ld_rd;
      wptr_d         = wptr_q + PW'(1);
    end
    if (resp_acc) rptr_d = rptr_q + PW'(1);
    case ({issue_acc, resp_acc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (ld_resp_valid && (cnt_q == '0));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
      for (int i = 0; i < MAX_LD; i++) fifo_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      fifo_q <= fifo_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
`ifdef REGFILE_BYPASS_EN
      // regs_d already holds this cycle's write. Busy is dropped when the
      // last pending response lands, but is kept if a new load to the same
      // register is issued in that cycle.
      rd_data[p*XLEN +: XLEN] = regs_d[rd_addr[p*AW +: AW]];
      rd_busy[p] = (pend_q[rd_addr[p*AW +: AW]] != '0) &&
                   (pend_d[rd_addr[p*AW +: AW]] != '0);
`else
      rd_data[p*XLEN +: XLEN] = regs_q[rd_addr[p*AW +: AW]];
      rd_busy[p] = (pend_q[rd_addr[p*AW +: AW]] != '0);
`endif
    end
  end

  assign ld_issue_ready = (cnt_q < MAX_CNT);
  assign ld_outstanding = cnt_q;
  assign resp_err       = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int MAX_LD = 4;
  localparam int AW = 5;
  localparam int CW = 3;

  logic                clock;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                alu_we;
  logic [AW-1:0]       alu_waddr;
  logic [XLEN-1:0]     alu_wdata;
  logic                ld_issue;
  logic [AW-1:0]       ld_rd;
  logic                ld_issue_ready;
  logic                ld_resp_valid;
  logic [XLEN-1:0]     ld_resp_data;
  logic [CW-1:0]       ld_outstanding;
  logic                resp_err;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .MAX_LD(MAX_LD)) dut (
    .clock(clock), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_issue_ready(ld_issue_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .ld_outstanding(ld_outstanding), .resp_err(resp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: an array of register values and a queue of load
  // destinations, in issue order.
  logic [XLEN-1:0] m_regs [NREGS];
  int              m_q [$];
  bit              m_err;

  function automatic int pend_count(input int a);
    int c = 0;
    if (a == 0) return 0;
    foreach (m_q[i]) if (m_q[i] == a) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
    m_q.delete();
    m_err = 0;
  endtask

  task automatic check_model();
    bit issue_ok, resp_ok;
    int a, c, c_next;
    logic [XLEN-1:0] exp_d;
    bit exp_b;
    issue_ok = ld_issue && (m_q.size() < MAX_LD);
    resp_ok  = ld_resp_valid && (m_q.size() > 0);
    for (int p = 0; p < NRD; p++) begin
      a = int'(rd_addr[p*AW +: AW]);
      c = pend_count(a);
`ifdef REGFILE_BYPASS_EN
      if (a == 0) exp_d = '0;
      else if (resp_ok && m_q[0] == a) exp_d = ld_resp_data;
      else if (alu_we && int'(alu_waddr) == a) exp_d = alu_wdata;
      else exp_d = m_regs[a];
      c_next = c;
      if (a != 0 && resp_ok && m_q[0] == a) c_next--;
      if (a != 0 && issue_ok && int'(ld_rd) == a) c_next++;
      exp_b = (c > 0) && (c_next > 0);
`else
      c_next = c;
      exp_d = m_regs[a];
      exp_b = (c_next > 0);
`endif
      chk($sformatf("model rd_data%0d", p), 64'(rd_data[p*XLEN +: XLEN]), 64'(exp_d));
      chk($sformatf("model rd_busy%0d", p), 64'(rd_busy[p]), 64'(exp_b));
    end
    chk("model ld_outstanding", 64'(ld_outstanding), 64'(m_q.size()));
    chk("model ld_issue_ready", 64'(ld_issue_ready), 64'(m_q.size() < MAX_LD));
    chk("model resp_err", 64'(resp_err), 64'(m_err));
  endtask

  task automatic model_commit();
    bit issue_ok, resp_ok;
    int h;
    if (reset) begin
      model_reset();
      return;
    end
    issue_ok = ld_issue && (m_q.size() < MAX_LD);
    resp_ok  = ld_resp_valid && (m_q.size() > 0);
    if (alu_we && alu_waddr != 0) m_regs[alu_waddr] = alu_wdata;
    if (resp_ok) begin
      h = m_q.pop_front();
      if (h != 0) m_regs[h] = ld_resp_data;
    end else if (ld_resp_valid) begin
      m_err = 1;
    end
    if (issue_ok) m_q.push_back(int'(ld_rd));
  endtask

  // Inputs are driven 1 time unit after a rising edge. The model check runs
  // mid-cycle, and the model is committed on the next edge.
  task automatic tick();
    #2;
    check_model();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic idle();
    alu_we = 0; alu_waddr = '0; alu_wdata = '0;
    ld_issue = 0; ld_rd = '0;
    ld_resp_valid = 0; ld_resp_data = '0;
  endtask

  typedef struct {
    logic            aw;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            iss;
    logic [AW-1:0]   lrd;
    logic            rv;
    logic [XLEN-1:0] rdat;
    logic [AW-1:0]   ra0, ra1;
    logic [XLEN-1:0] ed0, ed1;
    logic            eb0, eb1;
    logic [CW-1:0]   eout;
    logic            erdy, eerr;
  } vec_t;

  function automatic vec_t mk(bit aw, int wa, int wd, bit iss, int lrd, bit rv, int rdat,
                              int ra0, int ra1, int ed0, int ed1, bit eb0, bit eb1,
                              int eout, bit erdy, bit eerr);
    vec_t v;
    v.aw = aw; v.wa = AW'(wa); v.wd = XLEN'(wd);
    v.iss = iss; v.lrd = AW'(lrd); v.rv = rv; v.rdat = XLEN'(rdat);
    v.ra0 = AW'(ra0); v.ra1 = AW'(ra1);
    v.ed0 = XLEN'(ed0); v.ed1 = XLEN'(ed1); v.eb0 = eb0; v.eb1 = eb1;
    v.eout = CW'(eout); v.erdy = erdy; v.eerr = eerr;
    return v;
  endfunction

  vec_t vecs [15];

  initial begin
    // Each row: inputs for one cycle, plus the outputs expected in that
    // cycle from the state left by the earlier rows. Reads avoid registers
    // being written in the same cycle, so rows hold for both builds.
    vecs[0]  = mk(1, 1, 'h5,  0, 0, 0, 0,     3, 0, 0,    0,    0, 0, 0, 1, 0);
    vecs[1]  = mk(1, 0, 'hFF, 0, 0, 0, 0,     1, 0, 5,    0,    0, 0, 0, 1, 0);
    vecs[2]  = mk(0, 0, 0,    1, 2, 0, 0,     1, 0, 5,    0,    0, 0, 0, 1, 0);
    vecs[3]  = mk(0, 0, 0,    1, 3, 0, 0,     2, 0, 0,    0,    1, 0, 1, 1, 0);
    vecs[4]  = mk(0, 0, 0,    1, 2, 0, 0,     2, 1, 0,    5,    1, 0, 2, 1, 0);
    vecs[5]  = mk(0, 0, 0,    1, 4, 0, 0,     3, 2, 0,    0,    1, 1, 3, 1, 0);
    vecs[6]  = mk(0, 0, 0,    1, 6, 0, 0,     4, 2, 0,    0,    1, 1, 4, 0, 0);
    vecs[7]  = mk(0, 0, 0,    0, 0, 1, 'hA,   6, 3, 0,    0,    0, 1, 4, 0, 0);
    vecs[8]  = mk(0, 0, 0,    0, 0, 1, 'hB,   2, 4, 'hA,  0,    1, 1, 3, 1, 0);
    vecs[9]  = mk(0, 0, 0,    0, 0, 1, 'hC,   3, 1, 'hB,  5,    0, 0, 2, 1, 0);
    vecs[10] = mk(0, 0, 0,    0, 0, 1, 'hD,   2, 3, 'hC,  'hB,  0, 0, 1, 1, 0);
    vecs[11] = mk(0, 0, 0,    0, 0, 0, 0,     4, 2, 'hD,  'hC,  0, 0, 0, 1, 0);
    vecs[12] = mk(0, 0, 0,    0, 0, 1, 'h77,  4, 2, 'hD,  'hC,  0, 0, 0, 1, 0);
    vecs[13] = mk(0, 0, 0,    0, 0, 0, 0,     4, 3, 'hD,  'hB,  0, 0, 0, 1, 1);
    vecs[14] = mk(0, 0, 0,    0, 0, 0, 0,     2, 1, 'hC,  5,    0, 0, 0, 1, 1);

    reset = 1'b1;
    rd_addr = '0;
    idle();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 15; i++) begin
      alu_we = vecs[i].aw; alu_waddr = vecs[i].wa; alu_wdata = vecs[i].wd;
      ld_issue = vecs[i].iss; ld_rd = vecs[i].lrd;
      ld_resp_valid = vecs[i].rv; ld_resp_data = vecs[i].rdat;
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      chk($sformatf("row%0d rd_data0", i), 64'(rd_data[XLEN-1:0]), 64'(vecs[i].ed0));
      chk($sformatf("row%0d rd_data1", i), 64'(rd_data[2*XLEN-1:XLEN]), 64'(vecs[i].ed1));
      chk($sformatf("row%0d rd_busy0", i), 64'(rd_busy[0]), 64'(vecs[i].eb0));
      chk($sformatf("row%0d rd_busy1", i), 64'(rd_busy[1]), 64'(vecs[i].eb1));
      chk($sformatf("row%0d ld_outstanding", i), 64'(ld_outstanding), 64'(vecs[i].eout));
      chk($sformatf("row%0d ld_issue_ready", i), 64'(ld_issue_ready), 64'(vecs[i].erdy));
      chk($sformatf("row%0d resp_err", i), 64'(resp_err), 64'(vecs[i].eerr));
      tick();
    end

    // ALU write and load response to register 5 in the same cycle.
    idle();
    ld_issue = 1; ld_rd = 5; rd_addr = {5'd0, 5'd5};
    tick();
    idle();
    alu_we = 1; alu_waddr = 5; alu_wdata = 'h1;
    ld_resp_valid = 1; ld_resp_data = 'h2;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("same-cycle reg5 read", 64'(rd_data[XLEN-1:0]), 64'h2);
    chk("same-cycle reg5 busy", 64'(rd_busy[0]), 64'h0);
`else
    chk("same-cycle reg5 read", 64'(rd_data[XLEN-1:0]), 64'h0);
    chk("same-cycle reg5 busy", 64'(rd_busy[0]), 64'h1);
`endif
    tick();
    idle();
    #1;
    chk("reg5 after collision", 64'(rd_data[XLEN-1:0]), 64'h2);
    chk("reg5 busy after collision", 64'(rd_busy[0]), 64'h0);
    tick();

    // In-flight loads are dropped by reset; a later response is an error.
    ld_issue = 1; ld_rd = 7; tick();
    ld_rd = 8; tick();
    idle();
    #1;
    chk("two loads outstanding", 64'(ld_outstanding), 64'h2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_addr = {5'd8, 5'd7};
    #1;
    chk("after reset outstanding", 64'(ld_outstanding), 64'h0);
    chk("after reset resp_err", 64'(resp_err), 64'h0);
    chk("after reset reg5 cleared", 64'(dut.regs_q[5]), 64'h0);
    ld_resp_valid = 1; ld_resp_data = 'h99;
    tick();
    idle();
    #1;
    chk("stale resp sets resp_err", 64'(resp_err), 64'h1);
    chk("stale resp reg7", 64'(rd_data[XLEN-1:0]), 64'h0);
    chk("stale resp reg8", 64'(rd_data[2*XLEN-1:XLEN]), 64'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Random traffic checked against the model.
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 299) == 0);
      alu_we        = ($urandom_range(0, 1) == 1);
      alu_waddr     = AW'($urandom_range(0, NREGS - 1));
      alu_wdata     = $urandom;
      ld_issue      = ($urandom_range(0, 9) < 4);
      ld_rd         = AW'($urandom_range(0, 7));
      ld_resp_valid = ($urandom_range(0, 9) < 3);
      ld_resp_data  = $urandom;
      rd_addr       = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, register data width in bits.
REQ-002 Parameter NREGS, default 32, number of architectural registers (power of two, >=2); AW = clog2(NREGS).
REQ-003 Parameter NRD, default 2, number of independent read ports.
REQ-004 Parameter MAX_LD, default 4, maximum outstanding loads (power of two, >=2).
REQ-005 Port clock  input  1  clock; all state updates on rising edge.
REQ-006 Port reset  input  1  reset, synchronous, active-high.
REQ-007 Port rd_addr  input  NRD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
REQ-008 Port rd_data  output  NRD*XLEN  packed read data, same packing as rd_addr.
REQ-009 Port rd_busy  output  NRD  per port: addressed register has a load pending.
REQ-010 Port alu_we  input  1  ALU write-back enable.
REQ-011 Port alu_waddr  input  AW  ALU destination register.
REQ-012 Port alu_wdata  input  XLEN  ALU write-back data.
REQ-013 Port ld_issue  input  1  load issue request.
REQ-014 Port ld_rd  input  AW  load destination register.
REQ-015 Port ld_issue_ready  output  1  load issue can be accepted this cycle.
REQ-016 Port ld_resp_valid  input  1  memory returns load data; loads return in issue order.
REQ-017 Port ld_resp_data  input  XLEN  returned load data.
REQ-018 Port ld_outstanding  output  clog2(MAX_LD)+1  count of loads in flight.
REQ-019 Port resp_err  output  1  sticky flag: response arrived with no load outstanding.

Function
REQ-020 Reads are combinational: rd_data for port i is regs[rd_addr_i]; register 0 always reads 0.
REQ-021 ALU write: when alu_we=1 and alu_waddr!=0, regs[alu_waddr] <= alu_wdata at the clock edge; writes to register 0 are discarded.
REQ-022 Load issue is accepted when ld_issue=1 and ld_issue_ready=1; ld_rd is pushed into an in-order destination FIFO of depth MAX_LD.
REQ-023 ld_issue_ready = (ld_outstanding < MAX_LD), derived from registered state only; no bypass from same-cycle response.
REQ-024 Per-register pending counter (width clog2(MAX_LD)+1) increments on accepted issue to that register; register 0 never counts as pending.
REQ-025 rd_busy_i = 1 when pending counter of rd_addr_i is nonzero.
REQ-026 Response: when ld_resp_valid=1 and FIFO non-empty, pop head, write ld_resp_data to head register (unless 0), decrement its pending counter.
REQ-027 Response with FIFO empty: no register write, no pop, resp_err <= 1 and held until reset.
REQ-028 Simultaneous accepted issue and response: push and pop in same cycle, ld_outstanding unchanged; same register: pending counter unchanged.
REQ-029 ALU write and load response to same register in same cycle: load response data wins.
REQ-030 ALU write to a register with pending load: write performed, pending counter unaffected; later response overwrites.
REQ-031 FIFO pointers wrap modulo MAX_LD; full = outstanding==MAX_LD, empty = outstanding==0.

Reset
REQ-032 On reset=1 at a clock edge: all registers 0, FIFO empty, all pending counters 0, ld_outstanding 0, resp_err 0, ld_issue_ready 1.
REQ-033 Reset overrides simultaneous issue, response and ALU write; in-flight loads are dropped, later responses set resp_err.

Configuration
REQ-034 Macro REGFILE_BYPASS_EN defined: rd_data reflects the write landing this cycle (load response priority over ALU write, register 0 excluded), and rd_busy deasserts in the cycle the last pending response for that register arrives.
REQ-035 Macro REGFILE_BYPASS_EN undefined: rd_data and rd_busy reflect registered state only; written values visible the cycle after the edge.

Verification
REQ-036 Reset, then alu_we=1 waddr=1 wdata=0x5; next cycle rd_addr0=1 -> rd_data0=0x5; waddr=0 wdata=0xFF -> reg 0 reads 0.
REQ-037 Issue loads to regs 2,3,2,4 back-to-back -> ld_outstanding=4, ld_issue_ready=0, fifth issue ignored; rd_busy on reg 2 stays 1 after first response, clears after third.
REQ-038 Responses 0xA,0xB,0xC,0xD to the four loads -> reg2=0xC, reg3=0xB, reg4=0xD, ld_outstanding=0.
REQ-039 Same cycle: ALU write reg 5=0x1 and response for load to reg 5=0x2 -> reg5=0x2; bypass build shows 0x2 on rd_data that cycle, non-bypass build shows old value.
REQ-040 ld_resp_valid=1 with nothing outstanding -> resp_err=1, registers unchanged; stays 1 until reset.
REQ-041 Issue two loads, assert reset, then send response -> ld_outstanding=0 after reset, response sets resp_err=1, no register written.
